pg_serial_adder: RTL and testbench
==================================

Name: pg_serial_adder

Overview:
Digit-serial adder/subtractor that produces the per-bit propagate/generate terms and consumes them through a registered carry. It is the P/G-producing end of the lookahead carry path. Each cycle it converts one DIGIT-bit slice of the operands into P/G, resolves that slice's carry chain, and folds the carry into the next cycle. It sits beside the combinational lookahead adder for area-constrained datapaths, under a start/done handshake.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per clock.
NUM_DIGITS, WIDTH/DIGIT, derived (localparam, not overridable); latency in RUN cycles.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
sub  input  1  0 = a+b, 1 = a-b; latched with start.
a  input  WIDTH  operand A; latched with start.
b  input  WIDTH  operand B; latched with start.
busy  output  1  high while state is RUN.
done  output  1  one-cycle pulse; result valid.
sum  output  WIDTH  result; held from done until the next accepted start.
cout  output  1  carry out of the MSB. For sub=1 it is 1 when there is no borrow.
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
grp_p  output  1  word group propagate; see Optional Feature.
grp_g  output  1  word group generate; see Optional Feature.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, sum, cout, overflow, grp_p, grp_g all 0; digit counter and carry register 0. Applies immediately, including mid-RUN; any partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - Latch a into op_a.
  - Latch b into op_b, inverted if sub=1.
  - carry <= sub; counter <= 0; sum <= 0; go to RUN.
- RUN, each edge E1..E(NUM_DIGITS), with i = counter:
  - Per bit: p = op_a^op_b, g = op_a&op_b over slice [i*DIGIT +: DIGIT].
  - Ripple: c[j+1] = g[j] | (p[j] & c[j]), c[0] = carry.
  - Sum bits: s[j] = p[j] ^ c[j], written into sum[i*DIGIT +: DIGIT].
  - carry <= c[DIGIT]; counter <= counter+1.
- On the last digit (counter == NUM_DIGITS-1):
  - cout <= c[DIGIT]; overflow <= c[DIGIT-1] ^ c[DIGIT].
  - Go to DONE with done <= 1 registered, so done is high in the cycle after E(NUM_DIGITS).
- Latency: done is seen NUM_DIGITS+1 edges after start is sampled; throughput is one operation per NUM_DIGITS+2 cycles.
- DONE: done=1 for exactly one cycle, then IDLE. start during DONE is ignored.
- start while busy or in DONE is ignored. Operands are not re-sampled mid-operation; a/b/sub may change freely after E0.
- sum is updated digit by digit during RUN. Only the value at and after done is defined to be meaningful.
- Wrap-around: sums wrap modulo 2^WIDTH; the carry appears on cout only.

Optional Feature:
Macro PG_GROUP_OUT_EN.
- Defined:
  - A second register gacc (reset 0, cleared at accept) accumulates gacc <= G_d | (P_d & gacc) per digit, where P_d = AND of p and G_d is the digit generate with carry-in 0.
  - A register pacc (set 1 at accept) accumulates pacc <= pacc & P_d.
  - At done, grp_p = pacc and grp_g = gacc; both are held until the next start. This lets the block feed a higher lookahead level.
- Not defined: grp_p and grp_g are tied to 0 and the accumulators are not built.

Decomposition:
- Shared package/header pg_defs holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH/DIGIT;
  - the NUM_DIGITS calculation and a counter-width function (clog2).
- One natural sub-module, pg_digit: purely combinational, DIGIT bits.
  - Inputs: a, b, cin.
  - Outputs: s, cout, c_msb_in (carry into the top bit), P_d, G_d.
  - The top level instantiates it once and owns the FSM and registers.

Test Plan:
All scenarios use WIDTH=16, DIGIT=4.
1. a=0x1234, b=0x4321, sub=0, start pulsed → busy for 4 cycles, done pulse, sum=0x5555, cout=0, overflow=0.
2. a=0xFFFF, b=0x0001, sub=0 → sum=0x0000, cout=1, overflow=0. a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, overflow=1.
3. a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0 (borrow), overflow=0. a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, overflow=1.
4. Start 0x0001+0x0001, then re-pulse start with a=0xFFFF at RUN cycle 2 → second start ignored, sum=0x0002, exactly one done.
5. rst asserted at RUN cycle 2 → all outputs 0 immediately, no done. Then 0x00FF+0x0001 after release → sum=0x0100.
6. With PG_GROUP_OUT_EN, a=0x00FF, b=0xFF00 → sum=0xFFFF, grp_p=1, grp_g=0. a=0x8000, b=0x8000 → grp_p=0, grp_g=1, cout=1. Without the macro → grp_p=grp_g=0 always.

Source files
------------

// File: rtl/pg_defs.sv
// Shared definitions for the digit-serial P/G adder.
// State encoding, default geometry and width helpers.
package pg_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIGIT = 4;

    function automatic int num_digits(input int w, input int d);
        return w / d;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pg_digit.sv
// One DIGIT-bit slice: per-bit P/G, ripple carry, digit P/G.
// Purely combinational; the parent owns all state.
module pg_digit
    import pg_defs::*;
#(
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] s_o,
    output logic             cout_o,
    output logic             c_msb_in_o,
    output logic             p_d_o,
    output logic             g_d_o
);

    logic [DIGIT-1:0] p;
    logic [DIGIT-1:0] g;
    logic [DIGIT:0]   c;
    logic             gz;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Ripple the slice carry; gz is the same chain seeded with 0.
    always_comb begin
        c    = '0;
        gz   = 1'b0;
        c[0] = cin_i;
        for (int j = 0; j < DIGIT; j++) begin
            c[j+1] = g[j] | (p[j] & c[j]);
            gz     = g[j] | (p[j] & gz);
        end
    end

    assign s_o        = p ^ c[DIGIT-1:0];
    assign cout_o     = c[DIGIT];
    assign c_msb_in_o = c[DIGIT-1];
    assign p_d_o      = &p;
    assign g_d_o      = gz;

endmodule

// File: rtl/pg_serial_adder.sv
// Digit-serial add/sub producing P/G with a registered carry.
// Optional group P/G outputs: define PG_GROUP_OUT_EN.
module pg_serial_adder
    import pg_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             grp_p,
    output logic             grp_g
);

    localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
    localparam int CW         = cnt_width(NUM_DIGITS);
    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_c;
    logic             dig_cm;
    logic             dig_p;
    logic             dig_g;
    logic             accept;
    logic             last;

    assign accept = (state_q == IDLE) && start;
    assign last   = (state_q == RUN) && (cnt_q == LAST);

    pg_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a_i       (op_a_q[cnt_q*DIGIT +: DIGIT]),
        .b_i       (op_b_q[cnt_q*DIGIT +: DIGIT]),
        .cin_i     (carry_q),
        .s_o       (dig_s),
        .cout_o    (dig_c),
        .c_msb_in_o(dig_cm),
        .p_d_o     (dig_p),
        .g_d_o     (dig_g)
    );

    // Next state and datapath: latch on accept, one digit per RUN cycle.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[cnt_q*DIGIT +: DIGIT] = dig_s;
                carry_d = dig_c;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    cout_d  = dig_c;
                    ovf_d   = dig_cm ^ dig_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

`ifdef PG_GROUP_OUT_EN
    logic pacc_q, pacc_d;
    logic gacc_q, gacc_d;
    logic gp_q, gp_d;
    logic gg_q, gg_d;

    // Fold digit P/G into word group P/G; publish on the last digit.
    always_comb begin
        pacc_d = pacc_q;
        gacc_d = gacc_q;
        gp_d   = gp_q;
        gg_d   = gg_q;
        if (accept) begin
            pacc_d = 1'b1;
            gacc_d = 1'b0;
            gp_d   = 1'b0;
            gg_d   = 1'b0;
        end else if (state_q == RUN) begin
            pacc_d = pacc_q & dig_p;
            gacc_d = dig_g | (dig_p & gacc_q);
            if (last) begin
                gp_d = pacc_d;
                gg_d = gacc_d;
            end
        end
    end

    // Group accumulator and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pacc_q <= 1'b0;
            gacc_q <= 1'b0;
            gp_q   <= 1'b0;
            gg_q   <= 1'b0;
        end else begin
            pacc_q <= pacc_d;
            gacc_q <= gacc_d;
            gp_q   <= gp_d;
            gg_q   <= gg_d;
        end
    end

    assign grp_p = gp_q;
    assign grp_g = gg_q;
`else
    logic unused_pg;
    assign unused_pg = dig_p ^ dig_g ^ accept ^ last;
    assign grp_p     = 1'b0;
    assign grp_g     = 1'b0;
`endif

endmodule

// File: tb/tb_pg_serial_adder.sv
// Self-checking bench for pg_serial_adder (WIDTH=16, DIGIT=4).
// Vector table plus hand-written restart and reset sequences.
module tb_pg_serial_adder;

    localparam int W  = 16;
    localparam int ND = 4;
`ifdef PG_GROUP_OUT_EN
    localparam bit GRP_EN = 1'b1;
`else
    localparam bit GRP_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        logic         gp;
        logic         gg;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, overflow, grp_p, grp_g;
    logic [W-1:0] sum;

    int errors = 0;
    int checks = 0;
    vec_t exp_q[$];
    vec_t tbl[9];

    pg_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .overflow(overflow),
        .grp_p   (grp_p),
        .grp_g   (grp_g)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic vs, input logic [W-1:0] es,
                                input logic eco, input logic eov,
                                input logic egp, input logic egg);
        vec_t v;
        v.a = va; v.b = vb; v.sub = vs; v.s = es;
        v.co = eco; v.ov = eov; v.gp = egp; v.gg = egg;
        return v;
    endfunction

    // Independent word-level reference for random operands.
    function automatic vec_t model(input logic [W-1:0] va,
                                   input logic [W-1:0] vb, input logic vs);
        vec_t v;
        logic [W-1:0] bb;
        logic [W:0]   t;
        logic [W:0]   t0;
        bb  = vs ? ~vb : vb;
        t   = {1'b0, va} + {1'b0, bb} + {{W{1'b0}}, vs};
        t0  = {1'b0, va} + {1'b0, bb};
        v.a = va; v.b = vb; v.sub = vs;
        v.s  = t[W-1:0];
        v.co = t[W];
        v.ov = (va[W-1] == bb[W-1]) && (t[W-1] != va[W-1]);
        v.gp = &(va ^ bb);
        v.gg = t0[W];
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        vec_t e;
        int   k;
        int   nbusy;
        bit   seen;
        a = v.a; b = v.b; sub = v.sub; start = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        k = 1; nbusy = 0; seen = 0;
        while (!seen && k <= 20) begin
            if (done) seen = 1;
            else begin
                if (busy) nbusy++;
                @(negedge clk);
                k++;
            end
        end
        e = exp_q.pop_front();
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected done within 20");
            return;
        end
        chk("latency", 32'(k), 32'(ND + 1));
        chk("busy_cycles", 32'(nbusy), 32'(ND));
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.co));
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("grp_p", 32'(grp_p), GRP_EN ? 32'(e.gp) : 32'(0));
        chk("grp_g", 32'(grp_g), GRP_EN ? 32'(e.gg) : 32'(0));
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'(0));
        chk("sum_hold", 32'(sum), 32'(e.s));
    endtask

    initial begin
        int ndone;
        tbl[0] = mk(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        tbl[2] = mk(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        tbl[3] = mk(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[4] = mk(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
        tbl[5] = mk(16'h00FF, 16'hFF00, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl[6] = mk(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        tbl[7] = mk(16'h0001, 16'hFFFF, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        tbl[8] = mk(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);

        #12;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
        chk("rst_ovf", 32'(overflow), 32'(0));
        chk("rst_grp", 32'({grp_p, grp_g}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_op(tbl[i]);
        for (int i = 0; i < 6; i++)
            run_op(model(W'($urandom), W'($urandom), 1'($urandom)));

        // Restart attempt mid-RUN and during DONE must be ignored.
        a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) begin
                ndone++;
                chk("restart_sum", 32'(sum), 32'h0002);
                start = 1'b1;
                @(negedge clk);
                chk("start_in_done", 32'(busy), 32'(0));
                start = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        chk("restart_ndone", 32'(ndone), 32'(1));

        // Asynchronous reset in the middle of RUN.
        run_op(mk(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1));
        a = 16'h1111; b = 16'h1111; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_sum", 32'(sum), 32'(0));
        chk("mid_rst_cout", 32'(cout), 32'(0));
        chk("mid_rst_grp", 32'({grp_p, grp_g}), 32'(0));
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mid_rst_nodone", 32'(ndone), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        run_op(mk(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
